// File: rtl/alu32.sv
// alu32: 32-bit integer ALU with registered result, zero and signed-overflow flags.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       F,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             OF
);
  logic [WIDTH-1:0] w_b, w_sum, w_r;
  logic             w_ovf, w_slt;
  logic [WIDTH-1:0] r_y;
  logic             r_zero, r_of;
  // One adder serves add, sub and slt: F[2] inverts B and supplies the carry-in.
  always_comb begin
    w_b   = F[2] ? ~B : B;
    w_sum = A + w_b + {{(WIDTH-1){1'b0}}, F[2]};
    w_ovf = (A[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    w_slt = w_sum[WIDTH-1] ^ w_ovf;
    w_r   = F[1:0] == 2'b00 ? A & w_b :
            F[1:0] == 2'b01 ? A | w_b :
            F[1:0] == 2'b10 ? w_sum :
            F[2]            ? {{(WIDTH-1){1'b0}}, w_slt} : A ^ B;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y    <= '0;
      r_zero <= 1'b1;
      r_of   <= 1'b0;
    end else begin
      r_y    <= w_r;
      r_zero <= w_r == '0;
      r_of   <= F[1:0] == 2'b10 && w_ovf;
    end
  end
  assign Y    = r_y;
  assign zero = r_zero;
  assign OF   = r_of;
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed-vector self-checking bench for alu32, applied back-to-back.
module tb_alu32;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, y;
  logic [2:0]  f;
  logic        zero, of;
  int          n_run = 0, n_fail = 0;

  alu32 dut (.clk(clk), .reset(reset), .A(a), .B(b), .F(f), .Y(y), .zero(zero), .OF(of));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [31:0] y;
    logic        z, o;
  } vec_t;

  vec_t vecs[21] = '{
    '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1},
    '{32'h00000002, 32'h00000003, 3'b010, 32'h00000005, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b1, 1'b0},
    '{32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 32'h0F0F0000, 1'b0, 1'b0},
    '{32'hFFFF0000, 32'h0F0F0F0F, 3'b001, 32'hFFFF0F0F, 1'b0, 1'b0},
    '{32'hFFFF0000, 32'h0F0F0F0F, 3'b011, 32'hF0F00F0F, 1'b0, 1'b0},
    '{32'hFFFF0000, 32'h0F0F0F0F, 3'b100, 32'hF0F00000, 1'b0, 1'b0},
    '{32'hFFFF0000, 32'h0F0F0F0F, 3'b101, 32'hFFFFF0F0, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0},
    '{32'h00000001, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1, 1'b0},
    '{32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000000, 3'b010, 32'h00000000, 1'b1, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1'b1, 1'b1},
    '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b0, 1'b1},
    '{32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0},
    '{32'h12345678, 32'h12345678, 3'b011, 32'h00000000, 1'b1, 1'b0},
    '{32'h12345678, 32'h0000FFFF, 3'b100, 32'h12340000, 1'b0, 1'b0},
    '{32'h00000000, 32'hFFFFFFFF, 3'b101, 32'h00000000, 1'b1, 1'b0}
  };

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got Y=%h zero=%b OF=%b, expected Y=%h zero=%b OF=%b",
               tag, got[33:2], got[1], got[0], exp[33:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf);
    a = ta;
    b = tb;
    f = tf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step(32'hFFFFFFFF, 32'h00000001, 3'b010);
    chk("reset1", {y, zero, of}, {32'h0, 1'b1, 1'b0});
    step(32'hFFFFFFFF, 32'h00000001, 3'b010);
    chk("reset2", {y, zero, of}, {32'h0, 1'b1, 1'b0});
    reset = 1'b0;
    step(32'hFFFFFFFF, 32'h00000001, 3'b010);
    chk("carry_discard", {y, zero, of}, {32'h0, 1'b1, 1'b0});
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].f);
      chk($sformatf("vec%0d", i), {y, zero, of}, {vecs[i].y, vecs[i].z, vecs[i].o});
    end
    #3;
    chk("hold", {y, zero, of}, {vecs[20].y, vecs[20].z, vecs[20].o});
    reset = 1'b1;
    step(32'h7FFFFFFF, 32'h00000001, 3'b010);
    chk("reset_mid", {y, zero, of}, {32'h0, 1'b1, 1'b0});
    reset = 1'b0;
    step(32'h00000003, 32'h00000004, 3'b110);
    chk("after_reset", {y, zero, of}, {32'hFFFFFFFF, 1'b0, 1'b0});
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
